vga_frame_buffer: RTL and testbench
===================================

// Module: vga_frame_buffer
// PURPOSE
//  Ping-pong frame store upstream of vga_controller. The masking pipeline streams a
//  processed image into the back bank in raster order over a valid/ready handshake.
//  vga_controller reads the front bank by row/col address and receives ram_pixel.
//  Banks swap at the start of vsync, and only once a complete frame has been written,
//  so the display never shows a partly written (torn) frame.
// PARAMETERS
//  IMG_W   320  image width in pixels (col_read range 0..IMG_W-1)
//  IMG_H   240  image height in lines (row_read range 0..IMG_H-1)
//  PIX_W   12   pixel width, RGB444 packed {r[11:8],g[7:4],b[3:0]}
// PORTS
//  clk        in   1      system clock, the same clk that feeds vga_controller
//  rst_n      in   1      asynchronous reset, active-low
//  wr_valid   in   1      write pixel valid
//  wr_ready   out  1      buffer can accept a pixel
//  wr_sof     in   1      qualifies wr_valid: this pixel is (0,0) of a new frame
//  wr_pixel   in   PIX_W  write pixel data
//  row_read   in   8      read row from vga_controller
//  col_read   in   9      read column from vga_controller
//  vga_vs     in   1      vsync from vga_controller (low during the sync pulse)
//  ram_pixel  out  PIX_W  pixel at (row_read,col_read) in the front bank, registered
//  frame_done out  1      back bank holds a complete frame and is waiting for a swap
//  swap_pulse out  1      one-cycle pulse on the clk cycle after a bank swap
// BEHAVIOUR
//  Reset: ram_pixel=0, wr_ready=1, frame_done=0, swap_pulse=0, front=bank0, back=bank1,
//   write address=0. Memory contents are not reset.
//  Storage: 2 banks of IMG_W*IMG_H words of PIX_W bits (bank-select bit + linear address).
//  Write: a transfer occurs when wr_valid&&wr_ready at the rising clk edge.
//   - Data goes to back[waddr]. waddr then increments by 1.
//   - With wr_sof=1, the pixel goes to address 0 and waddr becomes 1 (restarts the frame,
//     discards any partial frame).
//   - A write at address IMG_W*IMG_H-1 sets frame_done=1 and wr_ready=0 on the next cycle.
//  Write states: FILL (wr_ready=1) -> DONE (frame_done=1, wr_ready=0) -> FILL on swap.
//  Vsync detect: vga_vs passes through a 2-flop synchroniser, then a falling-edge detector.
//  Swap: on a detected vsync fall while frame_done=1:
//   - front and back toggle.
//   - frame_done=0, waddr=0, wr_ready=1.
//   - swap_pulse=1 for exactly one cycle.
//   A vsync fall while frame_done=0 does nothing: the old front frame repeats.
//  Read: raddr = row_read*IMG_W + col_read, computed combinationally (shift-add, 17 bits).
//   - ram_pixel <= front[raddr] each clk edge, so latency is 1 clk from address to data.
//   - If row_read>=IMG_H or col_read>=IMG_W, ram_pixel <= 0 next cycle.
//  Simultaneous events: a read at the swap edge uses the old front bank. Reads from the
//   next edge onward use the new bank. No write can coincide with a swap
//   (wr_ready=0 in DONE).
//  Reset mid-frame: all state returns to reset values at once. The partial frame is
//   dropped.
// CONFIGURATION
//  VGA_FB_TESTPAT_EN defined: adds input tp_en (1 bit).
//   - While tp_en=1, ram_pixel <= 8 vertical colour bars, with the same 1-clk latency.
//   - bar index = col_read/(IMG_W/8); colours in order: 0xFFF,0xFF0,0x0FF,0x0F0,
//     0xF0F,0xF00,0x00F,0x000.
//   - The out-of-range zero rule still applies. The write side and swaps are unaffected.
//  VGA_FB_TESTPAT_EN undefined: no tp_en port; ram_pixel always comes from memory.
// TESTING
//  1 Reset, then write 76800 pixels with pixel=addr[11:0] and sof on the first
//    -> frame_done=1, wr_ready=0 after the last pixel.
//  2 From test 1, pulse vga_vs low -> swap_pulse one cycle, about 3 clk after the fall.
//    Then read (row 1,col 5) -> ram_pixel=0x145 one clk later.
//  3 Vsync falls with a partial frame (1000 px) -> no swap_pulse, front data unchanged.
//    Writing stays enabled.
//  4 Mid-frame wr_sof with pixel 0xABC -> address 0 =0xABC after completion.
//    frame_done needs 76799 more pixels.
//  5 Read (row 240,col 0) and (row 0,col 320) -> ram_pixel=0x000.
//    Toggle rst_n low mid-write -> outputs at reset values asynchronously.
//  6 VGA_FB_TESTPAT_EN, tp_en=1: col_read 0,40,200,319 -> 0xFFF,0xFF0,0xF00,0x000.

Source files
------------

// File: rtl/vga_frame_buffer.sv
// ---------------------------------------------------------------------------
// vga_frame_buffer
//   Ping-pong frame store between the masking pipeline and vga_controller.
//   A frame is streamed into the back bank in raster order over a valid/ready
//   handshake. vga_controller reads the front bank by row/column. Banks swap
//   at a vsync falling edge, and only when the back bank holds a complete
//   frame, so the display never shows a partly written frame.
//
// Optional feature: define VGA_FB_TESTPAT_EN to add input tp_en, which
//   replaces memory read data with 8 vertical colour bars.
//
// Ports
//   clk        in   system clock (shared with vga_controller)
//   rst_n      in   asynchronous reset, active-low
//   wr_valid   in   write pixel valid
//   wr_ready   out  buffer can accept a pixel (write state FILL)
//   wr_sof     in   pixel is (0,0) of a new frame; restarts the write address
//   wr_pixel   in   write pixel, RGB444 {r,g,b}
//   row_read   in   read row from vga_controller
//   col_read   in   read column from vga_controller
//   vga_vs     in   vsync from vga_controller, low during the sync pulse
//   tp_en      in   colour-bar test pattern enable (VGA_FB_TESTPAT_EN only)
//   ram_pixel  out  registered pixel at (row_read,col_read) of the front bank
//   frame_done out  back bank is complete and waiting for a swap
//   swap_pulse out  one-cycle pulse on the cycle after a bank swap
// ---------------------------------------------------------------------------
module vga_frame_buffer #(
    parameter int unsigned IMG_W = 320,
    parameter int unsigned IMG_H = 240,
    parameter int unsigned PIX_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             wr_sof,
    input  logic [PIX_W-1:0] wr_pixel,
    input  logic [7:0]       row_read,
    input  logic [8:0]       col_read,
    input  logic             vga_vs,
`ifdef VGA_FB_TESTPAT_EN
    input  logic             tp_en,
`endif
    output logic [PIX_W-1:0] ram_pixel,
    output logic             frame_done,
    output logic             swap_pulse
);

    localparam int unsigned DEPTH = IMG_W * IMG_H;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [9:0]    ROW_LIM = 10'(IMG_H);
    localparam logic [9:0]    COL_LIM = 10'(IMG_W);

    typedef enum logic {
        S_FILL,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Two banks; r_front selects the displayed one, the other is written.
    logic [PIX_W-1:0] r_bank0 [0:DEPTH-1];
    logic [PIX_W-1:0] r_bank1 [0:DEPTH-1];

    logic             r_front;
    logic [AW-1:0]    r_waddr;
    logic             r_swap_pulse;
    logic [PIX_W-1:0] r_ram_pixel;

    logic             r_vs_meta;
    logic             r_vs_sync;
    logic             r_vs_prev;

    logic             w_wr_fire;
    logic [AW-1:0]    w_wr_addr;
    logic             w_vs_fall;
    logic             w_swap;
    logic [AW-1:0]    w_rd_addr;
    logic             w_rd_in_range;

    // ---------------------------------------------------------------------
    // Write side
    // ---------------------------------------------------------------------
    assign wr_ready   = (r_state == S_FILL);
    assign frame_done = (r_state == S_DONE);
    assign w_wr_fire  = wr_valid && wr_ready;
    // SOF forces the pixel to address 0, discarding any partial frame.
    assign w_wr_addr  = wr_sof ? '0 : r_waddr;

    // ---------------------------------------------------------------------
    // Vsync: two-flop synchroniser followed by a falling-edge detector.
    // The flops reset high (vsync idle level) so reset release never looks
    // like a sync pulse.
    // ---------------------------------------------------------------------
    assign w_vs_fall = r_vs_prev && !r_vs_sync;
    // DONE implies wr_ready=0, so a swap can never coincide with a write.
    assign w_swap    = (r_state == S_DONE) && w_vs_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_wr_fire && (w_wr_addr == LAST)) w_state_nxt = S_DONE;
            S_DONE:  if (w_vs_fall) w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front      <= 1'b0;
            r_waddr      <= '0;
            r_swap_pulse <= 1'b0;
            r_vs_meta    <= 1'b1;
            r_vs_sync    <= 1'b1;
            r_vs_prev    <= 1'b1;
        end else begin
            r_vs_meta    <= vga_vs;
            r_vs_sync    <= r_vs_meta;
            r_vs_prev    <= r_vs_sync;
            r_swap_pulse <= w_swap;
            if (w_swap) begin
                r_front <= ~r_front;
                r_waddr <= '0;
            end else if (w_wr_fire) begin
                // Wrap to 0 after the last pixel so the pointer never leaves
                // the bank; it is cleared again on swap anyway.
                r_waddr <= (w_wr_addr == LAST) ? '0 : w_wr_addr + 1'b1;
            end
        end
    end

    // Memory contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            if (r_front) begin
                r_bank0[w_wr_addr] <= wr_pixel;
            end else begin
                r_bank1[w_wr_addr] <= wr_pixel;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read side: linear address = row*IMG_W + col, one clock of latency.
    // A read on the swap edge still sees the old front bank because r_front
    // only changes on that same edge.
    // ---------------------------------------------------------------------
    assign w_rd_addr     = AW'(row_read) * AW'(IMG_W) + AW'(col_read);
    assign w_rd_in_range = (10'(row_read) < ROW_LIM) && (10'(col_read) < COL_LIM);

`ifdef VGA_FB_TESTPAT_EN
    localparam logic [8:0] BAR_W = 9'(IMG_W / 8);

    logic [2:0]       w_bar;
    logic [PIX_W-1:0] w_bar_color;

    assign w_bar = 3'(col_read / BAR_W);

    always_comb begin
        w_bar_color = '0;
        case (w_bar)
            3'd0:    w_bar_color = PIX_W'(12'hFFF);
            3'd1:    w_bar_color = PIX_W'(12'hFF0);
            3'd2:    w_bar_color = PIX_W'(12'h0FF);
            3'd3:    w_bar_color = PIX_W'(12'h0F0);
            3'd4:    w_bar_color = PIX_W'(12'hF0F);
            3'd5:    w_bar_color = PIX_W'(12'hF00);
            3'd6:    w_bar_color = PIX_W'(12'h00F);
            default: w_bar_color = PIX_W'(12'h000);
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_pixel <= '0;
        end else if (!w_rd_in_range) begin
            r_ram_pixel <= '0;
`ifdef VGA_FB_TESTPAT_EN
        end else if (tp_en) begin
            r_ram_pixel <= w_bar_color;
`endif
        end else if (r_front) begin
            r_ram_pixel <= r_bank1[w_rd_addr];
        end else begin
            r_ram_pixel <= r_bank0[w_rd_addr];
        end
    end

    assign ram_pixel  = r_ram_pixel;
    assign swap_pulse = r_swap_pulse;

endmodule

// File: tb/tb_vga_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_buffer
//   Drives vga_frame_buffer (reduced image size to keep runs short) with
//   randomised frames and reads. Expected read data comes from an image
//   model (two frame arrays plus a "displayed" index) and is queued when the
//   read is issued; a monitor pops and compares one clock later.
// ---------------------------------------------------------------------------
module tb_vga_frame_buffer;

    localparam int W = 48;
    localparam int H = 10;
    localparam int D = W * H;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_sof   = 1'b0;
    logic [11:0] wr_pixel = '0;
    logic [7:0]  row_read = '0;
    logic [8:0]  col_read = '0;
    logic        vga_vs   = 1'b1;
    logic        wr_ready;
    logic        frame_done;
    logic        swap_pulse;
    logic [11:0] ram_pixel;
`ifdef VGA_FB_TESTPAT_EN
    logic        tp_en    = 1'b0;
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif

    always #5 clk = ~clk;

    vga_frame_buffer #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_sof     (wr_sof),
        .wr_pixel   (wr_pixel),
        .row_read   (row_read),
        .col_read   (col_read),
        .vga_vs     (vga_vs),
`ifdef VGA_FB_TESTPAT_EN
        .tp_en      (tp_en),
`endif
        .ram_pixel  (ram_pixel),
        .frame_done (frame_done),
        .swap_pulse (swap_pulse)
    );

    int checks = 0;
    int errors = 0;

    // Image model: two stored frames, which one is displayed, write progress.
    logic [11:0] mdl [2][D];
    int          m_front = 0;
    int          m_wptr  = 0;
    bit          m_done  = 1'b0;

    logic [11:0] exp_q  [$];
    string       name_q [$];
    logic        rd_req  = 1'b0;
    logic        rd_pend = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void m_write(input logic [11:0] px, input bit sof);
        int a;
        a = sof ? 0 : m_wptr;
        mdl[1 - m_front][a] = px;
        m_wptr = a + 1;
        if (a == D - 1) m_done = 1'b1;
    endfunction

    function automatic logic [11:0] exp_pix(input int r, input int c);
        if (r >= H || c >= W) return 12'h000;
`ifdef VGA_FB_TESTPAT_EN
        if (tp_en) return bars[c / (W / 8)];
`endif
        return mdl[m_front][r * W + c];
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk) begin : monitor
        logic [11:0] e;
        string       n;
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h with no expected entry", ram_pixel);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, {20'h0, ram_pixel}, {20'h0, e});
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic push_pixel(input logic [11:0] px, input bit sof);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        check("wr_ready_fill", {31'h0, wr_ready}, 32'h1);
        wr_valid = 1'b1;
        wr_pixel = px;
        wr_sof   = sof;
        m_write(px, sof);
        @(negedge clk);
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
    endtask

    task automatic write_px(input int n, input bit sof_first, input bit addr_pat);
        logic [11:0] px;
        for (int i = 0; i < n; i++) begin
            px = addr_pat ? 12'(i) : 12'($urandom);
            push_pixel(px, sof_first && (i == 0));
        end
    endtask

    task automatic rd(input int r, input int c, input string nm);
        row_read = 8'(r);
        col_read = 9'(c);
        rd_req   = 1'b1;
        exp_q.push_back(exp_pix(r, c));
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic rd_end();
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_reads(input int n, input string nm);
        for (int i = 0; i < n; i++)
            rd($urandom_range(0, H - 1), $urandom_range(0, W - 1), nm);
    endtask

    // Pulse vsync low and watch swap_pulse over a bounded window.
    task automatic vsync_check(input string nm);
        bit exp_sw;
        int lat;
        int hi;
        exp_sw = m_done;
        lat    = -1;
        hi     = 0;
        vga_vs = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 4) vga_vs = 1'b1;
            if (swap_pulse) begin
                hi++;
                if (lat < 0) lat = i;
            end
        end
        check({nm, "_swap_pulses"}, 32'(hi), exp_sw ? 32'h1 : 32'h0);
        if (exp_sw) begin
            check({nm, "_swap_latency_2to4"}, {31'h0, (lat >= 2 && lat <= 4)}, 32'h1);
            m_front = 1 - m_front;
            m_wptr  = 0;
            m_done  = 1'b0;
        end
        check({nm, "_frame_done"}, {31'h0, frame_done}, {31'h0, m_done});
        check({nm, "_wr_ready"},   {31'h0, wr_ready},   {31'h0, !m_done});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int sel;

        repeat (3) @(negedge clk);
        check("rst_ram_pixel",  {20'h0, ram_pixel},  32'h0);
        check("rst_wr_ready",   {31'h0, wr_ready},   32'h1);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("rst_swap_pulse", {31'h0, swap_pulse}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full frame, pixel = address, SOF on the first pixel.
        write_px(D - 1, 1'b1, 1'b1);
        check("t1_done_before_last", {31'h0, frame_done}, 32'h0);
        push_pixel(12'(D - 1), 1'b0);
        check("t1_frame_done", {31'h0, frame_done}, 32'h1);
        check("t1_wr_ready",   {31'h0, wr_ready},   32'h0);
        // Offered pixels while full must be ignored.
        wr_valid = 1'b1;
        wr_pixel = 12'hEEE;
        repeat (2) @(negedge clk);
        wr_sof = 1'b1;
        repeat (2) @(negedge clk);
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
        check("t1_done_held", {31'h0, frame_done}, 32'h1);

        // Swap and read back.
        vsync_check("t2");
        rd(1, 5, "t2_r1c5");
        rd(0, 0, "t2_r0c0");
        rd(H - 1, W - 1, "t2_last");
        rand_reads(30, "t2_rand");
        rd_end();

        // Partial frame then vsync: no swap, old frame still shown.
        write_px(D / 2, 1'b1, 1'b0);
        vsync_check("t3");
        rand_reads(20, "t3_rand");
        rd_end();

        // Mid-frame SOF restarts; needs D-1 more pixels to complete.
        push_pixel(12'hABC, 1'b1);
        write_px(D - 2, 1'b0, 1'b0);
        check("t4_done_before_last", {31'h0, frame_done}, 32'h0);
        push_pixel(12'($urandom), 1'b0);
        check("t4_frame_done", {31'h0, frame_done}, 32'h1);
        vsync_check("t4");
        rd(0, 0, "t4_addr0_abc");
        rand_reads(30, "t4_rand");
        rd_end();

        // Out-of-range reads.
        rd(H, 0, "t5_row_oor");
        rd(0, W, "t5_col_oor");
        rd(240, 0, "t5_row240");
        rd(0, 320, "t5_col320");
        rd(255, 511, "t5_max_oor");
        rd_end();

        // Fill the back bank, then reset asynchronously with a write offered.
        write_px(D, 1'b1, 1'b0);
        check("t5_frame_done", {31'h0, frame_done}, 32'h1);
        sel = 0;
        for (int i = 0; i < D; i++) begin
            if (mdl[m_front][i] != 12'h000) begin
                sel = i;
                break;
            end
        end
        rd(sel / W, sel % W, "t5_pre_reset_rd");
        rd_end();
        wr_valid = 1'b1;
        wr_pixel = 12'h5A5;
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_ram_pixel",  {20'h0, ram_pixel},  32'h0);
        check("t5_async_wr_ready",   {31'h0, wr_ready},   32'h1);
        check("t5_async_frame_done", {31'h0, frame_done}, 32'h0);
        check("t5_async_swap_pulse", {31'h0, swap_pulse}, 32'h0);
        m_front = 0;
        m_wptr  = 0;
        m_done  = 1'b0;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_reads(20, "t5_post_reset_rd");
        rd_end();

        // After reset: partial frame dropped by SOF, full frame, swap.
        write_px(100, 1'b1, 1'b0);
        write_px(D, 1'b1, 1'b0);
        vsync_check("t5b");
        rd(0, 0, "t5b_r0c0");
        rand_reads(30, "t5b_rand");
        rd_end();

`ifdef VGA_FB_TESTPAT_EN
        tp_en = 1'b1;
        rd(0, 0, "t6_bar0");
        rd(3, W / 8, "t6_bar1");
        rd(5, 5 * W / 8, "t6_bar5");
        rd(H - 1, W - 1, "t6_bar7");
        rd(H, 0, "t6_oor");
        rd_end();
        tp_en = 1'b0;
        rd(2, 7, "t6_mem_again");
        rd_end();
`endif

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
